tmma_seq: RTL and testbench

TMMA_SEQ -- requirements
Module: tmma_seq

---
 rtl/tmma_seq_pkg.sv | 40 ++++
 rtl/tmma_seq_if.sv | 49 ++++
 rtl/tmma_seq_addr_gen.sv | 25 ++
 rtl/tmma_seq.sv | 115 +++++++++++
 tb/tb_tmma_seq.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tmma_seq_pkg.sv
// Shared definitions for the TMMA row sequencer: field widths, instruction
// type encodings, FSM state type and the latched-instruction record.
package tmma_seq_pkg;

  localparam int TINST_TYPE_WIDTH     = 2;
  localparam int TLOAD_DATAW_WIDTH    = 4;
  localparam int TMMA_PRECISION_WIDTH = 3;
  localparam int ADDR_WIDTH           = 32;
  localparam int DATAW_SH_W           = $clog2(TLOAD_DATAW_WIDTH);

  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_TMMA       = 2'd0;
  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADC   = 2'd1;
  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_POSTSTOREC = 2'd2;
  localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADA   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEQ   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [TINST_TYPE_WIDTH-1:0]     itype;
    logic [TLOAD_DATAW_WIDTH-1:0]    dataw;
    logic [ADDR_WIDTH-1:0]           addr0;
    logic [ADDR_WIDTH-1:0]           addr1;
    logic [TMMA_PRECISION_WIDTH-1:0] precision;
    logic                            acc;
  } tmma_inst_t;

  // Element size is one-hot in bytes; the highest set bit wins if it is not.
  function automatic logic [DATAW_SH_W-1:0] dataw_log2(input logic [TLOAD_DATAW_WIDTH-1:0] dw);
    logic [DATAW_SH_W-1:0] r;
    r = '0;
    for (int i = 0; i < TLOAD_DATAW_WIDTH; i++)
      if (dw[i]) r = DATAW_SH_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/tmma_seq_if.sv
// Issue bus, row-request bus and status of the TMMA sequencer.
// slave = the sequencer side, master = upstream issue logic plus the array.
interface tmma_seq_if
  import tmma_seq_pkg::*;
#(
    parameter int IDX_W = 4
) ();

    logic                            issue_tmma_valid_i;
    logic                            issue_tmma_ready_o;
    logic [TINST_TYPE_WIDTH-1:0]     issue_tmma_type_i;
    logic [TLOAD_DATAW_WIDTH-1:0]    issue_tmma_data_width_i;
    logic [ADDR_WIDTH-1:0]           issue_tmma_addr0_i;
    logic [ADDR_WIDTH-1:0]           issue_tmma_addr1_i;
    logic [TMMA_PRECISION_WIDTH-1:0] issue_tmma_precision_i;
    logic                            issue_tmma_acc_i;

    logic                            row_req_vld_o;
    logic                            row_req_rdy_i;
    logic [TINST_TYPE_WIDTH-1:0]     row_req_type_o;
    logic [TMMA_PRECISION_WIDTH-1:0] row_req_precision_o;
    logic                            row_req_acc_o;
    logic [ADDR_WIDTH-1:0]           row_req_addr0_o;
    logic [ADDR_WIDTH-1:0]           row_req_addr1_o;
    logic [IDX_W-1:0]                row_req_idx_o;
    logic                            row_req_last_o;

    logic                            busy_o;
    logic                            done_o;

    modport slave (
        input  issue_tmma_valid_i, issue_tmma_type_i, issue_tmma_data_width_i,
               issue_tmma_addr0_i, issue_tmma_addr1_i, issue_tmma_precision_i,
               issue_tmma_acc_i, row_req_rdy_i,
        output issue_tmma_ready_o, row_req_vld_o, row_req_type_o, row_req_precision_o,
               row_req_acc_o, row_req_addr0_o, row_req_addr1_o, row_req_idx_o,
               row_req_last_o, busy_o, done_o
    );

    modport master (
        output issue_tmma_valid_i, issue_tmma_type_i, issue_tmma_data_width_i,
               issue_tmma_addr0_i, issue_tmma_addr1_i, issue_tmma_precision_i,
               issue_tmma_acc_i, row_req_rdy_i,
        input  issue_tmma_ready_o, row_req_vld_o, row_req_type_o, row_req_precision_o,
               row_req_acc_o, row_req_addr0_o, row_req_addr1_o, row_req_idx_o,
               row_req_last_o, busy_o, done_o
    );

endinterface

// File: rtl/tmma_seq_addr_gen.sv
// Per-row address generation: base + idx * (TMMA_COLS << log2(element bytes)),
// wrapping modulo 2^ADDR_WIDTH.
module tmma_seq_addr_gen
  import tmma_seq_pkg::*;
#(
    parameter int TMMA_COLS = 16,
    parameter int IDX_W     = 4
) (
    input  logic [ADDR_WIDTH-1:0]        base0,
    input  logic [ADDR_WIDTH-1:0]        base1,
    input  logic [TLOAD_DATAW_WIDTH-1:0] dataw,
    input  logic [IDX_W-1:0]             idx,
    output logic [ADDR_WIDTH-1:0]        addr0,
    output logic [ADDR_WIDTH-1:0]        addr1
);

    logic [ADDR_WIDTH-1:0] stride;
    logic [ADDR_WIDTH-1:0] offs;

    assign stride = ADDR_WIDTH'(TMMA_COLS) << dataw_log2(dataw);
    assign offs   = ADDR_WIDTH'(idx) * stride;
    assign addr0  = base0 + offs;
    assign addr1  = base1 + offs;

endmodule

// File: rtl/tmma_seq.sv
// TMMA row sequencer: accepts one instruction, issues TMMA_ROWS row requests,
// waits DRAIN_CYCLES idle cycles, then pulses done_o and returns to IDLE.
module tmma_seq
  import tmma_seq_pkg::*;
#(
    parameter int TMMA_ROWS    = 16,
    parameter int TMMA_COLS    = 16,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    tmma_seq_if.slave io
);

    localparam int IDX_W      = (TMMA_ROWS > 1) ? $clog2(TMMA_ROWS) : 1;
    localparam int DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    seq_state_e        state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [DRAIN_W-1:0] drain_cnt, drain_nx;
    tmma_inst_t        inst;
    logic              accept, row_hs, last, done;

    assign accept = (state == ST_IDLE) && io.issue_tmma_valid_i;
    assign last   = (state == ST_SEQ) && (idx == IDX_W'(TMMA_ROWS - 1));
    assign row_hs = (state == ST_SEQ) && io.row_req_rdy_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            inst      <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            drain_cnt <= drain_nx;
            if (accept) begin
                inst.itype     <= io.issue_tmma_type_i;
                inst.dataw     <= io.issue_tmma_data_width_i;
                inst.addr0     <= io.issue_tmma_addr0_i;
                inst.addr1     <= io.issue_tmma_addr1_i;
                inst.precision <= io.issue_tmma_precision_i;
                inst.acc       <= io.issue_tmma_acc_i;
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        drain_nx = drain_cnt;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (io.issue_tmma_valid_i) begin
                    state_nx = ST_SEQ;
                    idx_nx   = '0;
                end
            end
            ST_SEQ: begin
                if (row_hs) begin
                    if (last) begin
                        // idx parks at 0 so idle outputs show the row-0 address
                        idx_nx   = '0;
                        drain_nx = '0;
                        if (DRAIN_CYCLES == 0) begin
                            state_nx = ST_IDLE;
                            done     = 1'b1;
                        end else begin
                            state_nx = ST_DRAIN;
                        end
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_LAST)) begin
                    state_nx = ST_IDLE;
                    drain_nx = '0;
                    done     = 1'b1;
                end else begin
                    drain_nx = drain_cnt + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    tmma_seq_addr_gen #(
        .TMMA_COLS(TMMA_COLS),
        .IDX_W    (IDX_W)
    ) u_addr_gen (
        .base0(inst.addr0),
        .base1(inst.addr1),
        .dataw(inst.dataw),
        .idx  (idx),
        .addr0(io.row_req_addr0_o),
        .addr1(io.row_req_addr1_o)
    );

    assign io.issue_tmma_ready_o  = (state == ST_IDLE);
    assign io.row_req_vld_o       = (state == ST_SEQ);
    assign io.row_req_type_o      = inst.itype;
    assign io.row_req_precision_o = inst.precision;
    assign io.row_req_acc_o       = inst.acc;
    assign io.row_req_idx_o       = idx;
    assign io.row_req_last_o      = last;
    assign io.busy_o              = (state != ST_IDLE);
    // An edge with reset asserted aborts the instruction, so no retire pulse.
    assign io.done_o              = done && rst_n;

endmodule

// File: tb/tb_tmma_seq.sv
// Directed bench for tmma_seq: reset idle, full instructions with rdy high and
// toggling, address wrap, back-to-back issue and mid-instruction reset.
module tb_tmma_seq;
  import tmma_seq_pkg::*;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int DRAIN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tmma_seq_if #(.IDX_W(4)) bus ();

  tmma_seq #(
    .TMMA_ROWS   (ROWS),
    .TMMA_COLS   (COLS),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_issue(input logic v, input logic [1:0] ty, input logic [3:0] dw,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [2:0] pr, input logic ac);
    bus.issue_tmma_valid_i      = v;
    bus.issue_tmma_type_i       = ty;
    bus.issue_tmma_data_width_i = dw;
    bus.issue_tmma_addr0_i      = a0;
    bus.issue_tmma_addr1_i      = a1;
    bus.issue_tmma_precision_i  = pr;
    bus.issue_tmma_acc_i        = ac;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done_o.
  task automatic run_inst(input string nm, input logic [1:0] ty, input logic [3:0] dw,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] stride, input bit toggle);
    int k = 0, cyc = 1, last_hs = -1, done_cyc = -1;
    bit r;
    chk({nm, ":ready_idle"}, 32'(bus.issue_tmma_ready_o), 32'd1);
    drive_issue(1'b1, ty, dw, a0, a1, 3'd5, 1'b1);
    @(negedge clk);
    // Garbage on the issue bus after acceptance must not reach the row stream.
    drive_issue(1'b0, ~ty, 4'b1000, 32'hDEAD_0000, 32'hBEEF_0000, 3'd2, 1'b0);
    while (cyc < 200) begin
      if (k < ROWS) begin
        chk({nm, ":vld"},   32'(bus.row_req_vld_o), 32'd1);
        chk({nm, ":idx"},   32'(bus.row_req_idx_o), 32'(k));
        chk({nm, ":addr0"}, bus.row_req_addr0_o, a0 + 32'(k) * stride);
        chk({nm, ":addr1"}, bus.row_req_addr1_o, a1 + 32'(k) * stride);
        chk({nm, ":last"},  32'(bus.row_req_last_o), 32'(k == ROWS - 1));
        chk({nm, ":type"},  32'(bus.row_req_type_o), 32'(ty));
        chk({nm, ":prec"},  32'(bus.row_req_precision_o), 32'd5);
        chk({nm, ":ready_busy"}, 32'(bus.issue_tmma_ready_o), 32'd0);
        chk({nm, ":done_early"}, 32'(bus.done_o), 32'd0);
        r = toggle ? (cyc % 2 == 1) : 1'b1;
        bus.row_req_rdy_i = r;
        if (r) begin
          if (k == ROWS - 1) last_hs = cyc;
          k++;
        end
      end else begin
        bus.row_req_rdy_i = 1'b1;
        if (bus.done_o) begin
          done_cyc = cyc;
          break;
        end
        chk({nm, ":drain_vld"}, 32'(bus.row_req_vld_o), 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    chk({nm, ":rows"}, 32'(k), 32'(ROWS));
    chk({nm, ":done_delay"}, 32'(done_cyc - last_hs), 32'(DRAIN));
    chk({nm, ":ready_at_done"}, 32'(bus.issue_tmma_ready_o), 32'd0);
    @(negedge clk);
    chk({nm, ":done_1cyc"}, 32'(bus.done_o), 32'd0);
    chk({nm, ":ready_after"}, 32'(bus.issue_tmma_ready_o), 32'd1);
    chk({nm, ":busy_after"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc;
    drive_issue(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 3'd0, 1'b0);
    bus.row_req_rdy_i = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and 10 idle cycles
    chk("rst:addr0", bus.row_req_addr0_o, 32'd0);
    chk("rst:done",  32'(bus.done_o), 32'd0);
    chk("rst:last",  32'(bus.row_req_last_o), 32'd0);
    chk("rst:type",  32'(bus.row_req_type_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("idle:ready", 32'(bus.issue_tmma_ready_o), 32'd1);
      chk("idle:vld",   32'(bus.row_req_vld_o), 32'd0);
      chk("idle:busy",  32'(bus.busy_o), 32'd0);
      @(negedge clk);
    end

    // 2-byte elements: stride 16*2 = 0x20
    run_inst("tmma_rdy1", TINST_TYPE_TMMA, 4'b0010, 32'h1000, 32'h2000, 32'h20, 1'b0);
    run_inst("tmma_tog",  TINST_TYPE_TMMA, 4'b0010, 32'h1000, 32'h2000, 32'h20, 1'b1);
    // 1-byte elements: stride 0x10, row 1 wraps to 0
    run_inst("wrap", TINST_TYPE_PRELOADC, 4'b0001, 32'hFFFF_FFF0, 32'h0000_0100, 32'h10, 1'b0);
    // 8-byte elements: stride 0x80
    run_inst("dw8", TINST_TYPE_PRELOADA, 4'b1000, 32'h0004_0000, 32'h0008_0040, 32'h80, 1'b0);

    // Back-to-back: valid held high; fields switched mid-flight must be ignored
    bus.row_req_rdy_i = 1'b1;
    drive_issue(1'b1, TINST_TYPE_TMMA, 4'b0100, 32'h3000, 32'h4000, 3'd1, 1'b0);
    done_cyc = -1;
    @(negedge clk);
    for (int c = 1; c <= 34; c++) begin
      if (c == 5) drive_issue(1'b1, TINST_TYPE_POSTSTOREC, 4'b0001, 32'h9000, 32'hA000, 3'd3, 1'b1);
      if (c <= 32) chk("b2b:ready_busy", 32'(bus.issue_tmma_ready_o), 32'd0);
      if (c == 8) chk("b2b:addr0_a", bus.row_req_addr0_o, 32'h3000 + 32'd7 * 32'h40);
      if (c == 8) chk("b2b:type_a", 32'(bus.row_req_type_o), 32'(TINST_TYPE_TMMA));
      if (bus.done_o && done_cyc < 0) done_cyc = c;
      if (c == 33) chk("b2b:ready_gap", 32'(bus.issue_tmma_ready_o), 32'd1);
      if (c == 34) begin
        chk("b2b:vld_b",   32'(bus.row_req_vld_o), 32'd1);
        chk("b2b:idx_b",   32'(bus.row_req_idx_o), 32'd0);
        chk("b2b:addr0_b", bus.row_req_addr0_o, 32'h9000);
        chk("b2b:type_b",  32'(bus.row_req_type_o), 32'(TINST_TYPE_POSTSTOREC));
        bus.issue_tmma_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b:done_cyc", 32'(done_cyc), 32'(ROWS + DRAIN));
    // Let B retire: it entered SEQ at c=34, so 31 more rows/drain cycles remain
    done_cyc = -1;
    for (int c = 0; c < 60; c++) begin
      if (bus.done_o) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    chk("b2b:done_b", 32'(done_cyc), 32'(ROWS + DRAIN - 2));
    @(negedge clk);

    // Reset in the middle of row 5
    drive_issue(1'b1, TINST_TYPE_TMMA, 4'b0010, 32'h5000, 32'h6000, 3'd0, 1'b0);
    @(negedge clk);
    bus.issue_tmma_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid:idx5", 32'(bus.row_req_idx_o), 32'd5);
    rst_n = 1'b0;
    chk("rst_mid:no_done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    chk("rst_mid:ready", 32'(bus.issue_tmma_ready_o), 32'd1);
    chk("rst_mid:busy",  32'(bus.busy_o), 32'd0);
    chk("rst_mid:vld",   32'(bus.row_req_vld_o), 32'd0);
    chk("rst_mid:done",  32'(bus.done_o), 32'd0);
    chk("rst_mid:addr0", bus.row_req_addr0_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_inst("post_rst", TINST_TYPE_TMMA, 4'b0010, 32'h1000, 32'h2000, 32'h20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
